instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Fetch stage feeding the main controller: holds the PC and issues word fetches to instruction memory over a req/ack handshake.
// - Buffers one instruction and presents it with a valid/ready handshake; opcode is exported as instr[6:0].
// - Accepts PC redirects from branch/jump resolution and discards any stale in-flight fetch.
// PARAMETERS
// - XLEN      32             address/PC width
// - RESET_PC  32'h0000_0000  first fetch address after reset
// - NOP_INSTR 32'h0000_0013  instr value held while invalid (addi x0,x0,0)
// PORTS
// - clk             in   1     single clock, rising edge
// - rst_n           in   1     asynchronous, active-low reset
// - imem_req        out  1     fetch request; held high until imem_ack
// - imem_addr       out  XLEN  fetch address; word aligned, stable while imem_req high
// - imem_ack        in   1     memory returns imem_rdata this cycle; only valid while imem_req high
// - imem_rdata      in   32    fetched instruction word
// - redirect_valid  in   1     one-cycle pulse: next fetch from redirect_pc
// - redirect_pc     in   XLEN  branch/jump target; bits [1:0] forced to 0
// - instr_valid     out  1     instr/instr_pc/opcode valid for decode
// - decode_ready    in   1     decode accepts instr this cycle
// - instr           out  32    buffered instruction
// - instr_pc        out  XLEN  PC of buffered instruction
// - opcode          out  7     instr[6:0], drives main controller Opcode
// - opcode_known    out  1     instr_valid and opcode is one of R/LOAD/STORE/BRANCH/OP-IMM/JALR/JAL
// BEHAVIOUR
// - Reset (async, rst_n=0): state=S_IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0,
//   instr=NOP_INSTR, instr_pc=0, drop=0, opcode_known=0. No request issued in the cycle reset deasserts.
// - States: S_IDLE, S_REQ, S_HOLD.
// - S_IDLE: next cycle -> S_REQ with imem_addr=pc.
// - S_REQ: imem_req=1. On imem_ack: if drop or redirect_valid this cycle -> discard rdata, clear drop, pc=new target,
//   stay S_REQ (new request next cycle). Else capture instr=imem_rdata, instr_pc=pc, instr_valid=1 -> S_HOLD.
// - S_REQ with redirect_valid and no ack: set drop=1, latch target into pc; imem_addr unchanged until ack (protocol rule).
// - Zero-wait memory (ack in first req cycle) legal; throughput = one instruction per 2 cycles minimum (req, hold).
// - S_HOLD: imem_req=0. If redirect_valid: instr_valid=0 next cycle, pc=redirect_pc, -> S_REQ (redirect wins over
//   decode_ready in same cycle; that instruction is treated as consumed). Else if decode_ready: instr_valid=0,
//   pc=instr_pc+4, -> S_REQ. Else hold all outputs stable.
// - PC arithmetic modulo 2^XLEN; pc=FFFF_FFFC + 4 wraps to 0 silently.
// - instr returns to NOP_INSTR whenever instr_valid drops; opcode follows instr combinationally.
// - imem_ack while imem_req=0 is ignored (bench asserts it never happens).
// - Reset mid-fetch: outstanding request abandoned; memory must tolerate imem_req dropping without ack.
// STRUCTURE
// - Shared package rv_pkg: opcode localparams (OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011,
//   OP_BRANCH=1100011, OP_IMM=0010011, OP_JALR=1100111, OP_JAL=1101111), NOP_INSTR, fetch state enum.
// - Same opcode constants used by main controller decode; no duplicated literals.
// - One flat module; no sub-module. Registers: state, pc, drop, instr, instr_pc, instr_valid.
// TESTING
// - Reset release, ack same cycle as req, decode_ready=1 -> addrs 0,4,8 fetched; instr_valid every 2nd cycle.
// - imem_ack delayed 3 cycles -> imem_addr stable for all 4 req cycles; instr=rdata, instr_pc=0.
// - decode_ready=0 for 5 cycles in S_HOLD -> instr/instr_pc frozen, imem_req=0; release -> next addr instr_pc+4.
// - redirect_pc=0x100 during wait, ack 2 cycles later -> that rdata dropped, next imem_addr=0x100, instr_pc=0x100.
// - redirect_valid with ack same cycle, redirect_pc=0x203 -> rdata dropped, next imem_addr=0x200.
// - rst_n low mid-S_REQ -> imem_req=0, instr_valid=0 immediately; refetch from RESET_PC; opcode 1110011 -> opcode_known=0.

Source files
------------

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared RISC-V definitions for the fetch stage and the main controller decode.
//   - OP_* : 7-bit base opcodes recognised by the controller
//   - NOP_INSTR : canonical no-op (addi x0,x0,0) shown while no instruction is valid
//   - fetch_state_e : fetch sequencer states
//   - is_known_opcode() : true for the opcodes the controller decodes
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic is_known_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_IMM, OP_JALR, OP_JAL: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: keeps the PC, fetches one word at a time from instruction
// memory over a req/ack handshake, buffers one instruction for decode behind a
// valid/ready handshake and honours PC redirects from branch/jump resolution.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and word address (stable while req high)
//   imem_ack/rdata    memory response, only meaningful while imem_req is high
//   redirect_valid/pc one-cycle redirect pulse and target (bits [1:0] ignored)
//   instr_valid       buffered instruction valid for decode
//   decode_ready      decode consumes the buffered instruction
//   instr/instr_pc    buffered instruction and its PC (NOP_INSTR while invalid)
//   opcode            instr[6:0]
//   opcode_known      instr_valid and opcode is one the controller decodes
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            decode_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic            opcode_known
);

    import rv_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_ADDR = RESET_PC & ALIGN_MASK;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    // Address presented to memory; separate from pc so it can stay stable while
    // a redirect target is already latched into pc during an in-flight fetch.
    logic [XLEN-1:0] addr_q, addr_d;
    logic            drop_q, drop_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;

    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] refetch_tgt;
    logic [XLEN-1:0] seq_pc;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    // A redirect arriving with the ack beats a target latched earlier.
    assign refetch_tgt  = redirect_valid ? redirect_tgt : pc_q;
    assign seq_pc       = instr_pc_q + XLEN'(4);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        drop_d        = drop_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d   = redirect_tgt;
                    addr_d = redirect_tgt;
                end else begin
                    addr_d = pc_q;
                end
            end

            S_REQ: begin
                if (imem_ack) begin
                    if (drop_q || redirect_valid) begin
                        // Stale data: throw it away and refetch from the target.
                        pc_d   = refetch_tgt;
                        addr_d = refetch_tgt;
                        drop_d = 1'b0;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = addr_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Memory still owns addr_q; remember the target until the ack.
                    drop_d = 1'b1;
                    pc_d   = redirect_tgt;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    pc_d          = redirect_tgt;
                    addr_d        = redirect_tgt;
                    state_d       = S_REQ;
                end else if (decode_ready) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    pc_d          = seq_pc;
                    addr_d        = seq_pc;
                    state_d       = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_ADDR;
            addr_q        <= RESET_ADDR;
            drop_q        <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            drop_q        <= drop_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req     = (state_q == S_REQ);
    assign imem_addr    = addr_q;
    assign instr_valid  = instr_valid_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign opcode       = instr_q[6:0];
    assign opcode_known = instr_valid_q && is_known_opcode(instr_q[6:0]);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Randomised bench for instr_fetch_unit. A transaction-level model tracks
// what the fetch stage should be showing (outstanding fetch address, pending
// redirect, buffered instruction) and every cycle's outputs are compared
// against it. Memory latency, decode back-pressure, redirects and mid-fetch
// resets are drawn from $urandom with per-phase probabilities.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        decode_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        opcode_known;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .decode_ready   (decode_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .opcode_known   (opcode_known)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_deliv = 0;
    int unsigned n_drops = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_busy    : a fetch is outstanding at m_addr
    // m_stale   : that fetch was overtaken by a redirect; m_next is where to go
    // m_fresh   : reset has just been released, first fetch not yet started
    logic        m_busy, m_stale, m_fresh, m_valid;
    logic [31:0] m_addr, m_next, m_instr, m_ipc;

    function automatic logic known_op(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0010011, 7'b1100111, 7'b1101111};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_fresh = 1'b1;
        m_valid = 1'b0;
        m_addr  = RST_PC;
        m_next  = RST_PC;
        m_instr = NOP;
        m_ipc   = 32'h0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (m_fresh) begin
            m_fresh = 1'b0;
            m_busy  = 1'b1;
            m_addr  = redirect_valid ? tgt : RST_PC;
        end else if (m_busy) begin
            if (imem_ack) begin
                if (m_stale || redirect_valid) begin
                    m_addr  = redirect_valid ? tgt : m_next;
                    m_stale = 1'b0;
                    n_drops++;
                end else begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                    m_instr = imem_rdata;
                    m_ipc   = m_addr;
                    n_deliv++;
                end
            end else if (redirect_valid) begin
                m_stale = 1'b1;
                m_next  = tgt;
            end
        end else if (m_valid && (redirect_valid || decode_ready)) begin
            m_valid = 1'b0;
            m_instr = NOP;
            m_busy  = 1'b1;
            m_addr  = redirect_valid ? tgt : m_ipc + 32'd4;
        end
    endtask

    task automatic check_outputs();
        chk("imem_req",     {63'b0, imem_req},     {63'b0, m_busy});
        chk("imem_addr",    {32'b0, imem_addr},    {32'b0, m_addr});
        chk("instr_valid",  {63'b0, instr_valid},  {63'b0, m_valid});
        chk("instr",        {32'b0, instr},        {32'b0, m_instr});
        chk("instr_pc",     {32'b0, instr_pc},     {32'b0, m_ipc});
        chk("opcode",       {57'b0, opcode},       {57'b0, m_instr[6:0]});
        chk("opcode_known", {63'b0, opcode_known}, {63'b0, m_valid && known_op(m_instr[6:0])});
    endtask

    // ---------------- stimulus helpers ----------------
    logic [6:0] op_tab [8] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b0010011, 7'b1100111, 7'b1101111, 7'b1110011};

    function automatic logic [31:0] make_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 4) != 0) w[6:0] = op_tab[$urandom_range(0, 7)];
        return w;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0203;
            2:       return 32'hFFFF_FFFC;
            3:       return 32'hFFFF_FFFE;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_in_reset();
        chk("rst_req",    {63'b0, imem_req},     64'd0);
        chk("rst_valid",  {63'b0, instr_valid},  64'd0);
        chk("rst_instr",  {32'b0, instr},        {32'b0, NOP});
        chk("rst_addr",   {32'b0, imem_addr},    {32'b0, RST_PC});
        chk("rst_known",  {63'b0, opcode_known}, 64'd0);
    endtask

    int unsigned ph_cycles [4] = '{200, 800, 800, 600};
    int unsigned ph_ack    [4] = '{100, 30, 60, 100};
    int unsigned ph_rdy    [4] = '{100, 40, 70, 50};
    int unsigned ph_red    [4] = '{0, 8, 15, 20};
    int unsigned ph_rst    [4] = '{0, 0, 5, 10};   // per mille, only while req high

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_in_reset();
        chk("rst_ipc", {32'b0, instr_pc}, 64'd0);
        rst_n = 1'b1;
        model_step();

        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < int'(ph_cycles[p]); c++) begin
                @(negedge clk);
                check_outputs();

                imem_ack       = imem_req && ($urandom_range(0, 99) < ph_ack[p]);
                imem_rdata     = make_word();
                redirect_valid = ($urandom_range(0, 99) < ph_red[p]);
                redirect_pc    = pick_target();
                decode_ready   = ($urandom_range(0, 99) < ph_rdy[p]);

                if (imem_req && ($urandom_range(0, 999) < ph_rst[p])) begin
                    imem_ack       = 1'b0;
                    redirect_valid = 1'b0;
                    decode_ready   = 1'b0;
                    rst_n          = 1'b0;
                    #1;
                    check_in_reset();
                    model_reset();
                    @(negedge clk);
                    check_in_reset();
                    rst_n = 1'b1;
                end
                model_step();
            end
        end

        @(negedge clk);
        check_outputs();
        chk("deliveries_seen", {63'b0, n_deliv > 100}, 64'd1);
        chk("drops_seen",      {63'b0, n_drops > 5},   64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
